// File: rtl/fb_burst_writer.sv
// Write-side frame buffer master: buffers a word stream in a FIFO and issues
// fixed-length write bursts into the back buffer, flipping buffers per frame.
module fb_burst_writer #(
  parameter int            AN    = 24,
  parameter int            DN    = 16,
  parameter int            BURST = 8,
  parameter logic [AN-1:0] BASE  = 24'hf00000,
  parameter logic [AN-1:0] SWAP  = 24'hf80000,
  parameter int            WORDS = 384000
) (
  input  logic                       clkSYS,
  input  logic                       reset,
  input  logic [DN-1:0]              in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       restart,
  output logic                       req,
  output logic                       req_wr,
  output logic [AN-1:0]              req_addr,
  output logic [DN-1:0]              req_data,
  input  logic                       req_ack,
  output logic                       front,
  output logic                       frame_done,
  output logic [$clog2(2*BURST):0]   level
);

  localparam int DEPTH = 2 * BURST;
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int CW    = $clog2(BURST);
  localparam logic [AN-1:0] BURST_A = AN'(BURST);
  localparam logic [AN-1:0] WORDS_A = AN'(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_STEP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   beat;
  logic [AN-1:0]   offset;
  logic            pend_restart;
  logic [DN-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, flush, frame_end;

  assign req      = (state == S_BURST);
  assign req_wr   = req;
  assign req_data = mem[rd_ptr];
  assign in_ready = (level != LW'(DEPTH));
  assign pop      = req & req_ack;

  // A restart seen mid-burst is deferred to STEP so the arbiter still gets
  // exactly BURST words; the flush then replaces the normal STEP update.
  assign flush = (restart && state != S_BURST) || (state == S_STEP && pend_restart);
  assign push  = in_valid & in_ready & ~restart & ~flush;

  assign frame_end  = (state == S_STEP) && !restart && !pend_restart &&
                      (offset == WORDS_A - BURST_A);
  assign frame_done = frame_end;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!restart && level >= LW'(BURST)) state_nxt = S_BURST;
      S_BURST: if (pop && beat == CW'(BURST - 1)) state_nxt = S_STEP;
      S_STEP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and level define validity,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clkSYS) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      beat         <= '0;
      offset       <= '0;
      front        <= 1'b0;
      req_addr     <= SWAP;
      pend_restart <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && state_nxt == S_BURST) begin
        req_addr <= (front ? BASE : SWAP) + offset;
        beat     <= '0;
      end else if (pop) begin
        beat <= beat + CW'(1);
      end

      if (restart && state == S_BURST) pend_restart <= 1'b1;

      if (state == S_STEP) begin
        pend_restart <= 1'b0;
        if (restart || pend_restart) begin
          offset <= '0;
        end else if (frame_end) begin
          offset <= '0;
          front  <= ~front;
        end else begin
          offset <= offset + BURST_A;
        end
      end else if (restart && state == S_IDLE) begin
        offset <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_burst_writer.sv
// Directed bench for fb_burst_writer with a 32-word frame so a buffer flip
// happens after four bursts.
module tb_fb_burst_writer;

  localparam int BURST = 8;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        req, req_wr;
  logic [23:0] req_addr;
  logic [15:0] req_data;
  logic        req_ack = 1'b0;
  logic        front, frame_done;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  fb_burst_writer #(
    .AN(24), .DN(16), .BURST(BURST),
    .BASE(24'hf00000), .SWAP(24'hf80000), .WORDS(32)
  ) dut (
    .clkSYS(clk_sys), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .restart(restart),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .req_ack(req_ack),
    .front(front), .frame_done(frame_done), .level(level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_words(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = first + 16'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40 && req !== 1'b1; i++) tick();
    check("req_rise", req, 1);
  endtask

  // Acks one burst with random gaps; optionally pulses restart on ack index restart_at.
  task automatic do_burst(input logic [23:0] addr, input logic [15:0] first,
                          input int gap_max, input logic exp_fd, input int restart_at);
    wait_req();
    check("burst_addr", req_addr, addr);
    check("burst_wr", req_wr, 1);
    for (int k = 0; k < BURST; k++) begin
      int gap;
      gap = int'($urandom_range(gap_max, 0));
      req_ack = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_req", req, 1);
        check("gap_addr", req_addr, addr);
      end
      req_ack = 1'b1;
      if (k == restart_at) begin
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hdead;
      end
      check("burst_req", req, 1);
      check("burst_data", req_data, first + 16'(k));
      tick();
      req_ack = 1'b0;
      if (k == restart_at) begin
        restart  = 1'b0;
        in_valid = 1'b0;
      end
    end
    check("req_drop", req, 0);
    check("frame_done", frame_done, exp_fd);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_req", req, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_front", front, 0);
    check("rst_addr", req_addr, 24'hf80000);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    tick();

    // First burst: latency, order, drain
    push_words(16'h0001, 8);
    check("lat_req_low", req, 0);
    check("lat_level", level, 8);
    tick();
    check("lat_req_high", req, 1);
    do_burst(24'hf80000, 16'h0001, 0, 1'b0, -1);
    check("drain_level", level, 0);

    // Full FIFO, withheld ack, simultaneous push and pop
    push_words(16'h0100, 16);
    check("full_level", level, 16);
    check("full_in_ready", in_ready, 0);
    check("full_addr", req_addr, 24'hf80008);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_req", req, 1);
      check("hold_addr", req_addr, 24'hf80008);
      check("hold_data", req_data, 16'h0100);
    end
    for (int k = 0; k < 7; k++) begin
      req_ack = 1'b1;
      check("full_data", req_data, 16'h0100 + 16'(k));
      tick();
    end
    req_ack = 1'b0;
    check("level_9", level, 9);
    in_valid = 1'b1;
    in_data  = 16'h0110;
    req_ack  = 1'b1;
    check("pp_data", req_data, 16'h0107);
    tick();
    in_valid = 1'b0;
    req_ack  = 1'b0;
    check("pp_level", level, 9);
    check("pp_req_drop", req, 0);
    tick();
    check("gap2_req", req, 0);
    do_burst(24'hf80010, 16'h0108, 2, 1'b0, -1);

    // Full frame with random ack gaps, then buffer flip
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int b = 0; b < 4; b++) begin
      push_words(16'(16'h0020 + 8 * b), 8);
      do_burst(24'hf80000 + 24'(8 * b), 16'(16'h0020 + 8 * b), 3, (b == 3), -1);
    end
    tick();
    check("flip_front", front, 1);
    check("flip_fd_low", frame_done, 0);
    push_words(16'h0040, 8);
    do_burst(24'hf00000, 16'h0040, 2, 1'b0, -1);

    // Restart during the 3rd ack: burst completes, then flush and offset 0
    push_words(16'h0200, 16);
    do_burst(24'hf00008, 16'h0200, 1, 1'b0, 2);
    tick();
    check("rs_level", level, 0);
    check("rs_front", front, 1);
    check("rs_req", req, 0);
    push_words(16'h0300, 8);
    do_burst(24'hf00000, 16'h0300, 1, 1'b0, -1);

    // Restart in IDLE with a partial FIFO
    push_words(16'h0310, 4);
    check("idle_pre_level", level, 4);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("idle_rs_level", level, 0);
    check("idle_rs_req", req, 0);
    push_words(16'h0320, 8);
    do_burst(24'hf00000, 16'h0320, 1, 1'b0, -1);

    // Reset mid-burst
    push_words(16'h0400, 8);
    wait_req();
    check("mid_addr", req_addr, 24'hf00008);
    req_ack = 1'b1;
    tick();
    tick();
    req_ack = 1'b0;
    check("mid_req_before", req, 1);
    reset = 1'b1;
    #1;
    check("async_req", req, 0);
    check("async_req_wr", req_wr, 0);
    tick();
    tick();
    check("mrst_level", level, 0);
    check("mrst_front", front, 0);
    check("mrst_addr", req_addr, 24'hf80000);
    check("mrst_in_ready", in_ready, 1);
    reset = 1'b0;
    tick();
    push_words(16'h0500, 8);
    do_burst(24'hf80000, 16'h0500, 2, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
